// File: rtl/bp_be_dcache_req_arbiter.sv
// Round-robin arbiter sharing the backend dcache request port between requesters,
// with an LR/SC reservation lock (timeout-released) and fence.i drain sequencing.
module bp_be_dcache_req_arbiter #(
  parameter int unsigned num_req_p      = 2,
  parameter int unsigned pkt_width_p    = 64,
  parameter int unsigned lock_timeout_p = 64
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p-1:0]             req_v_i,
  input  logic [num_req_p*pkt_width_p-1:0] req_pkt_i,
  input  logic [num_req_p-1:0]             req_lr_i,
  input  logic [num_req_p-1:0]             req_sc_i,
  input  logic [num_req_p-1:0]             req_fencei_i,
  output logic [num_req_p-1:0]             req_yumi_o,
  output logic                             dcache_pkt_v_o,
  output logic [pkt_width_p-1:0]           dcache_pkt_o,
  input  logic                             dcache_ready_i,
  input  logic                             dcache_busy_i,
  output logic [$clog2(num_req_p)-1:0]     grant_id_o,
  output logic                             lock_v_o
);

  localparam int unsigned id_w  = $clog2(num_req_p);
  localparam int unsigned cnt_w = $clog2(lock_timeout_p + 1);
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(lock_timeout_p);
  localparam logic [cnt_w-1:0] cnt_hit = cnt_w'(lock_timeout_p - 1);

  typedef enum logic [1:0] {IDLE, LOCKED, FENCE} state_e;

  state_e           state_r, state_n;
  logic [id_w-1:0]  ptr_r, ptr_n, owner_r, owner_n, pend_id_r, last_id_r;
  logic [id_w-1:0]  grant, cand;
  logic [cnt_w-1:0] cnt_r, cnt_n;
  logic             pend_r, has_grant, accept, open, timeout;
  logic             acc_lr, acc_sc, acc_fencei;
  logic [num_req_p-1:0]   elig;
  logic [pkt_width_p-1:0] pkts [num_req_p];

  for (genvar i = 0; i < num_req_p; i++) begin : g_pkt
    assign pkts[i] = req_pkt_i[i*pkt_width_p +: pkt_width_p];
  end

  // The cycle that observes the fence drain complete already arbitrates as IDLE.
  always_comb begin
    open = (state_r == IDLE) || (state_r == FENCE && !dcache_busy_i);
    elig = '0;
    if (open) elig = req_v_i;
    else if (state_r == LOCKED) elig[owner_r] = req_v_i[owner_r];

    has_grant = 1'b0;
    grant     = ptr_r;
    cand      = '0;
    if (pend_r) begin
      has_grant = 1'b1;
      grant     = pend_id_r;
    end else begin
      for (int unsigned i = 0; i < num_req_p; i++) begin
        cand = id_w'((32'(ptr_r) + i) % num_req_p);
        if (!has_grant && elig[cand]) begin
          has_grant = 1'b1;
          grant     = cand;
        end
      end
    end
  end

  always_comb begin
    dcache_pkt_v_o = has_grant && !reset_i;
    accept         = dcache_pkt_v_o && dcache_ready_i;
    req_yumi_o     = '0;
    if (accept) req_yumi_o[grant] = 1'b1;
    dcache_pkt_o   = dcache_pkt_v_o ? pkts[grant] : '0;
    grant_id_o     = reset_i ? '0 : (dcache_pkt_v_o ? grant : last_id_r);
    lock_v_o       = (state_r == LOCKED) && !reset_i;
    acc_lr         = accept && req_lr_i[grant];
    acc_sc         = accept && req_sc_i[grant];
    acc_fencei     = accept && req_fencei_i[grant];
    // Any visible grant (accepted or stalled) defers the lock timeout.
    timeout        = (cnt_r >= cnt_hit) && !dcache_pkt_v_o;
  end

  always_comb begin
    state_n = state_r;
    owner_n = owner_r;
    cnt_n   = cnt_r;
    ptr_n   = ptr_r;
    if (accept) ptr_n = (grant == id_w'(num_req_p - 1)) ? '0 : grant + 1'b1;
    case (state_r)
      LOCKED: begin
        cnt_n = (cnt_r == cnt_max) ? cnt_r : cnt_r + 1'b1;
        if (acc_fencei) begin
          state_n = FENCE;
          cnt_n   = '0;
        end else if (acc_sc) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (acc_lr) begin
          cnt_n   = '0;
        end else if (timeout) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        if (open) begin
          state_n = IDLE;
          if (acc_fencei) begin
            state_n = FENCE;
          end else if (acc_lr) begin
            state_n = LOCKED;
            owner_n = grant;
            cnt_n   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= IDLE;
      ptr_r     <= '0;
      owner_r   <= '0;
      cnt_r     <= '0;
      pend_r    <= 1'b0;
      pend_id_r <= '0;
      last_id_r <= '0;
    end else begin
      state_r   <= state_n;
      ptr_r     <= ptr_n;
      owner_r   <= owner_n;
      cnt_r     <= cnt_n;
      pend_r    <= dcache_pkt_v_o && !dcache_ready_i;
      pend_id_r <= grant;
      if (dcache_pkt_v_o) last_id_r <= grant;
    end
  end

  for (genvar i = 0; i < num_req_p; i++) begin : g_flag_chk
    a_one_kind: assert property (@(posedge clk_i) disable iff (reset_i)
      req_v_i[i] |-> $onehot0({req_lr_i[i], req_sc_i[i], req_fencei_i[i]}));
  end

endmodule

// File: tb/tb_bp_be_dcache_req_arbiter.sv
// Scoreboard bench for bp_be_dcache_req_arbiter: two requesters, lock timeout of 8.
module tb_bp_be_dcache_req_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_v = '0, req_lr = '0, req_sc = '0, req_fi = '0;
  logic [127:0] req_pkt;
  logic [1:0]   yumi;
  logic         pkt_v, ready = 1'b0, busy = 1'b0, lock_v;
  logic [63:0]  pkt;
  logic [0:0]   grant_id;

  logic [63:0] pk [2];
  int errors = 0;
  int checks = 0;
  int exp_last = 0;

  typedef struct {
    string       tag;
    logic        v;
    int          id;
    logic [1:0]  yumi;
    logic        lock;
    logic [63:0] pkt;
  } exp_t;
  exp_t sb[$];
  exp_t e_s;

  always #5 clk = ~clk;

  initial begin
    pk[0] = 64'hA5A5_0000_0000_0001;
    pk[1] = 64'h5A5A_1111_2222_0002;
  end
  assign req_pkt = {pk[1], pk[0]};

  bp_be_dcache_req_arbiter #(
    .num_req_p(2),
    .pkt_width_p(64),
    .lock_timeout_p(8)
  ) dut (
    .clk_i(clk),
    .reset_i(rst),
    .req_v_i(req_v),
    .req_pkt_i(req_pkt),
    .req_lr_i(req_lr),
    .req_sc_i(req_sc),
    .req_fencei_i(req_fi),
    .req_yumi_o(yumi),
    .dcache_pkt_v_o(pkt_v),
    .dcache_pkt_o(pkt),
    .dcache_ready_i(ready),
    .dcache_busy_i(busy),
    .grant_id_o(grant_id),
    .lock_v_o(lock_v)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs it must produce.
  task automatic cyc(input logic [1:0] v, input logic [1:0] lr, input logic [1:0] sc,
                     input logic [1:0] fi, input logic rdy, input logic bsy,
                     input logic ev, input int eid, input logic elk, input string tag);
    exp_t e;
    req_v = v; req_lr = lr; req_sc = sc; req_fi = fi; ready = rdy; busy = bsy;
    e.tag  = tag;
    e.v    = ev;
    if (ev) exp_last = eid;
    e.id   = exp_last;
    e.yumi = (ev && rdy) ? (2'b01 << eid) : 2'b00;
    e.lock = elk;
    e.pkt  = ev ? pk[eid] : 64'h0;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      e_s = sb.pop_front();
      check({e_s.tag, "_v"},    64'(pkt_v),    64'(e_s.v));
      check({e_s.tag, "_yumi"}, 64'(yumi),     64'(e_s.yumi));
      check({e_s.tag, "_id"},   64'(grant_id), 64'(e_s.id));
      check({e_s.tag, "_lock"}, 64'(lock_v),   64'(e_s.lock));
      check({e_s.tag, "_pkt"},  pkt,           e_s.pkt);
    end
  end

  initial begin
    req_v = 2'b11; ready = 1'b1;
    #1;
    check("rst_v", 64'(pkt_v), 64'd0);
    check("rst_yumi", 64'(yumi), 64'd0);
    check("rst_lock", 64'(lock_v), 64'd0);
    check("rst_id", 64'(grant_id), 64'd0);
    check("rst_pkt", pkt, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // round robin with both requesting
    for (int i = 0; i < 6; i++) cyc(2'b11, 0, 0, 0, 1, 0, 1, i % 2, 0, "rr");

    // stalled grant held until ready
    cyc(2'b01, 0, 0, 0, 0, 0, 1, 0, 0, "stall0");
    cyc(2'b11, 0, 0, 0, 0, 0, 1, 0, 0, "stall1");
    cyc(2'b11, 0, 0, 0, 0, 0, 1, 0, 0, "stall2");
    cyc(2'b11, 0, 0, 0, 1, 0, 1, 0, 0, "stall_acc");
    cyc(2'b10, 0, 0, 0, 1, 0, 1, 1, 0, "stall_next");

    // LR then SC from req1
    cyc(2'b10, 2'b10, 0, 0, 1, 0, 1, 1, 0, "sc_lr");
    for (int i = 0; i < 4; i++) cyc(2'b01, 0, 0, 0, 1, 0, 0, 0, 1, "sc_locked");
    cyc(2'b11, 0, 2'b10, 0, 1, 0, 1, 1, 1, "sc_sc");
    cyc(2'b01, 0, 0, 0, 1, 0, 1, 0, 0, "sc_after");

    // lock timeout without SC
    cyc(2'b10, 2'b10, 0, 0, 1, 0, 1, 1, 0, "to_lr");
    for (int i = 0; i < 8; i++) cyc(2'b01, 0, 0, 0, 1, 0, 0, 0, 1, "to_locked");
    cyc(2'b01, 0, 0, 0, 1, 0, 1, 0, 0, "to_after");

    // timeout deferred by an owner grant stalled on ready
    cyc(2'b10, 2'b10, 0, 0, 1, 0, 1, 1, 0, "df_lr");
    for (int i = 0; i < 7; i++) cyc(2'b01, 0, 0, 0, 1, 0, 0, 0, 1, "df_locked");
    cyc(2'b11, 0, 0, 0, 0, 0, 1, 1, 1, "df_wait0");
    cyc(2'b11, 0, 0, 0, 0, 0, 1, 1, 1, "df_wait1");
    cyc(2'b11, 0, 0, 0, 1, 0, 1, 1, 1, "df_acc");
    cyc(2'b01, 0, 0, 0, 1, 0, 0, 0, 1, "df_expire");
    cyc(2'b01, 0, 0, 0, 1, 0, 1, 0, 0, "df_after");

    // fence.i drain
    cyc(2'b01, 0, 0, 2'b01, 1, 0, 1, 0, 0, "fn_acc");
    for (int i = 0; i < 4; i++) cyc(2'b10, 0, 0, 0, 1, 1, 0, 0, 0, "fn_busy");
    cyc(2'b10, 0, 0, 0, 1, 0, 1, 1, 0, "fn_done");

    // fence.i from the lock owner drops the lock
    cyc(2'b01, 2'b01, 0, 0, 1, 0, 1, 0, 0, "fl_lr");
    cyc(2'b01, 0, 0, 2'b01, 1, 0, 1, 0, 1, "fl_fi");
    cyc(2'b10, 0, 0, 0, 1, 0, 1, 1, 0, "fl_out");

    // asynchronous reset while locked with a stalled grant
    cyc(2'b10, 2'b10, 0, 0, 1, 0, 1, 1, 0, "ar_lr");
    cyc(2'b11, 0, 0, 0, 0, 0, 1, 1, 1, "ar_pend");
    rst = 1'b1;
    #1;
    check("ar_v", 64'(pkt_v), 64'd0);
    check("ar_yumi", 64'(yumi), 64'd0);
    check("ar_lock", 64'(lock_v), 64'd0);
    check("ar_id", 64'(grant_id), 64'd0);
    check("ar_pkt", pkt, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_last = 0;
    cyc(2'b10, 0, 0, 0, 1, 0, 1, 1, 0, "ar_post");
    cyc(2'b00, 0, 0, 0, 1, 0, 0, 0, 0, "ar_hold");

    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
